// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipeline_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instmem address/data, hazard/redirect controls, IF/ID outputs.
interface fetch_stage_if;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output inst_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_fault, fetch_count,
    input  inst, stall, redirect, redirect_target
  );

  modport slave (
    input  inst_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_fault, fetch_count,
    output inst, stall, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Load/flush/hold pipeline register of if_id_t; flush and reset load a bubble.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, RUN/FAULT FSM, fetch counter, IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc_p0;
  logic [31:0]  pc4_p0;
  logic [31:0]  count;
  logic         aligned;
  logic         in_run;
  logic         load;
  logic         flush;
  if_id_t       if_id_d_p0;
  if_id_t       if_id_p1;

  assign pc4_p0  = pc_p0 + 32'd4;
  assign aligned = (bus.redirect_target[1:0] == 2'b00);
  assign in_run  = (state == RUN);

  // Redirect squashes the wrong-path word even when stall is also asserted.
  assign flush = !in_run || bus.redirect;
  assign load  = in_run && !bus.stall;

  assign if_id_d_p0 = '{inst: bus.inst, pc4: pc4_p0, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_p0 <= RESET_PC;
      count <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect) begin
            if (aligned) pc_p0 <= bus.redirect_target;
            else         state <= FAULT;
          end else if (!bus.stall) begin
            pc_p0 <= pc4_p0;
            count <= count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- IF/ID boundary ----
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (if_id_d_p0),
    .q     (if_id_p1)
  );

  assign bus.inst_addr   = pc_p0;
  assign bus.if_id_inst  = if_id_p1.inst;
  assign bus.if_id_pc4   = if_id_p1.pc4;
  assign bus.if_id_valid = if_id_p1.valid;
  assign bus.fetch_fault = (state == FAULT);
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: run, stall, redirect, fault, PC wrap and reset priority.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus  ();
  fetch_stage_if bus2 ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  // Instruction memory model: 0x11,0x22,0x33,0x44 at 0..C, else A000_0000 | addr.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return ({30'h0, a[3:2]} + 32'd1) * 32'h11;
    return 32'hA000_0000 | a;
  endfunction

  always_comb bus.inst  = mem_word(bus.inst_addr);
  always_comb bus2.inst = mem_word(bus2.inst_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                         input logic [31:0] pc4, input logic valid, input logic fault,
                         input logic [31:0] cnt);
    chk({tag, ".addr"},  bus.inst_addr, addr);
    chk({tag, ".inst"},  bus.if_id_inst, inst);
    chk({tag, ".pc4"},   bus.if_id_pc4, pc4);
    chk({tag, ".valid"}, {31'h0, bus.if_id_valid}, {31'h0, valid});
    chk({tag, ".fault"}, {31'h0, bus.fetch_fault}, {31'h0, fault});
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_target = 32'h0;
    step();
    rst = 1'b0;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    chk("wrap.addr0", bus2.inst_addr, 32'hFFFF_FFF8);

    // Free run
    step();
    chk_all("run1", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 32'd1);
    chk("wrap.addr1", bus2.inst_addr, 32'hFFFF_FFFC);
    chk("wrap.pc4_1", bus2.if_id_pc4, 32'hFFFF_FFFC);
    step();
    chk_all("run2", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 32'd2);
    chk("wrap.addr2", bus2.inst_addr, 32'h0000_0000);
    chk("wrap.pc4_2", bus2.if_id_pc4, 32'h0000_0000);
    chk("wrap.inst2", bus2.if_id_inst, 32'hFFFF_FFFC);

    // Stall three cycles at PC=8
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 32'd2);
    end
    bus.stall = 1'b0;
    step();
    chk_all("resume", 32'hC, 32'h33, 32'hC, 1'b1, 1'b0, 32'd3);

    // Redirect together with stall at PC=C
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h40;
    step();
    chk_all("redir", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
    bus.stall = 1'b0; bus.redirect = 1'b0;
    step();
    chk_all("redir_t1", 32'h44, 32'hA000_0040, 32'h44, 1'b1, 1'b0, 32'd4);
    step();
    chk_all("redir_t2", 32'h48, 32'hA000_0044, 32'h48, 1'b1, 1'b0, 32'd5);

    // Misaligned redirect
    bus.redirect = 1'b1; bus.redirect_target = 32'h42;
    step();
    chk_all("fault", 32'h48, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
    bus.redirect = 1'b0;
    step();
    chk_all("fault_hold", 32'h48, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
    bus.redirect = 1'b1; bus.redirect_target = 32'h80;
    step();
    chk_all("fault_ign", 32'h48, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
    bus.redirect = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("fault_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    // Reset beats a simultaneous redirect mid-stream
    step();
    step();
    chk_all("prerst", 32'h8, 32'h22, 32'h8, 1'b1, 1'b0, 32'd2);
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h40;
    step();
    rst = 1'b0; bus.redirect = 1'b0;
    chk_all("rst_win", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    step();
    chk_all("post_rst", 32'h4, 32'h11, 32'h4, 1'b1, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
